splt_me: RTL and testbench



---
 rtl/splt_me_if.sv | 74 +++++++
 rtl/splt_me.sv | 210 +++++++++++++++++++++
 tb/tb_splt_me.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/splt_me_if.sv
`default_nettype none
// ============================================================================
// Module      : splt_me_if
// Description : ICB bundle for the 1-to-N splitter. Carries the upstream
//               master-side command/response channels and the flattened
//               per-slave downstream command/response channels.
//               The 'slave' modport is the splitter's view; the 'master'
//               modport is the view of the environment driving it.
// Revision    : 1.0 - initial release
// ============================================================================
interface splt_me_if #(
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int USR_W    = 1,
    parameter int SPLT_NUM = 4
) ();
    // upstream command channel
    logic                      i_icb_cmd_vld;
    logic                      i_icb_cmd_rdy;
    logic                      i_icb_cmd_read;
    logic [AW-1:0]             i_icb_cmd_addr;
    logic [DW-1:0]             i_icb_cmd_wdata;
    logic [DW/8-1:0]           i_icb_cmd_wmask;
    logic [USR_W-1:0]          i_icb_cmd_usr;
    // upstream response channel
    logic                      i_icb_rsp_vld;
    logic                      i_icb_rsp_rdy;
    logic                      i_icb_rsp_err;
    logic [DW-1:0]             i_icb_rsp_rdata;
    logic [USR_W-1:0]          i_icb_rsp_usr;
    // downstream command channels, slice i belongs to slave i
    logic [SPLT_NUM-1:0]       o_bus_icb_cmd_vld;
    logic [SPLT_NUM-1:0]       o_bus_icb_cmd_rdy;
    logic [SPLT_NUM-1:0]       o_bus_icb_cmd_read;
    logic [SPLT_NUM*AW-1:0]    o_bus_icb_cmd_addr;
    logic [SPLT_NUM*DW-1:0]    o_bus_icb_cmd_wdata;
    logic [SPLT_NUM*DW/8-1:0]  o_bus_icb_cmd_wmask;
    logic [SPLT_NUM*USR_W-1:0] o_bus_icb_cmd_usr;
    // downstream response channels
    logic [SPLT_NUM-1:0]       o_bus_icb_rsp_vld;
    logic [SPLT_NUM-1:0]       o_bus_icb_rsp_rdy;
    logic [SPLT_NUM-1:0]       o_bus_icb_rsp_err;
    logic [SPLT_NUM*DW-1:0]    o_bus_icb_rsp_rdata;
    logic [SPLT_NUM*USR_W-1:0] o_bus_icb_rsp_usr;

    modport slave (
        input  i_icb_cmd_vld, i_icb_cmd_read, i_icb_cmd_addr,
               i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_cmd_usr,
        output i_icb_cmd_rdy,
        output i_icb_rsp_vld, i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_usr,
        input  i_icb_rsp_rdy,
        output o_bus_icb_cmd_vld, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
               o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask, o_bus_icb_cmd_usr,
        input  o_bus_icb_cmd_rdy,
        input  o_bus_icb_rsp_vld, o_bus_icb_rsp_err, o_bus_icb_rsp_rdata,
               o_bus_icb_rsp_usr,
        output o_bus_icb_rsp_rdy
    );

    modport master (
        output i_icb_cmd_vld, i_icb_cmd_read, i_icb_cmd_addr,
               i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_cmd_usr,
        input  i_icb_cmd_rdy,
        input  i_icb_rsp_vld, i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_usr,
        output i_icb_rsp_rdy,
        input  o_bus_icb_cmd_vld, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
               o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask, o_bus_icb_cmd_usr,
        output o_bus_icb_cmd_rdy,
        output o_bus_icb_rsp_vld, o_bus_icb_rsp_err, o_bus_icb_rsp_rdata,
               o_bus_icb_rsp_usr,
        input  o_bus_icb_rsp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/splt_me.sv
`default_nettype none
// ============================================================================
// Module      : splt_me
// Description : 1-to-N ICB splitter. Each upstream command is routed to one
//               of SPLT_NUM slaves by base/mask address decode (lowest
//               matching index wins). The target of every accepted command
//               is queued in an in-order tracking FIFO; responses are only
//               taken from the slave at the FIFO head, so the master always
//               sees responses in command order.
//               Optional macro SPLT_ERR_RSP_EN: adds an internal error slot
//               that accepts unmatched commands and answers them with
//               err=1, rdata=0 and the command's usr. Without it, unmatched
//               addresses go to the last port (default slave).
// Revision    : 1.0 - initial release
// ============================================================================
module splt_me #(
    parameter int                     AW        = 32,
    parameter int                     DW        = 64,
    parameter int                     USR_W     = 1,
    parameter int                     SPLT_NUM  = 4,
    parameter int                     FIFO_DP   = 2,
    parameter logic [SPLT_NUM*AW-1:0] SPLT_BASE = {32'h8000_0000, 32'h1000_0000,
                                                   32'h0200_0000, 32'h0000_0000},
    parameter logic [SPLT_NUM*AW-1:0] SPLT_MASK = {4{32'hF000_0000}}
) (
    input  wire logic  clk,
    input  wire logic  rst,
    splt_me_if.slave   bus
);

`ifdef SPLT_ERR_RSP_EN
    // one extra select bit for the internal error responder
    localparam int c_SEL_W = SPLT_NUM + 1;
`else
    localparam int c_SEL_W = SPLT_NUM;
`endif
    localparam int                 c_PTR_W    = (FIFO_DP > 1) ? $clog2(FIFO_DP) : 1;
    localparam int                 c_CNT_W    = $clog2(FIFO_DP + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DP - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DP);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [SPLT_NUM-1:0] w_hit;
    logic [c_SEL_W-1:0]  w_sel;
    logic                w_found;
    logic                w_sel_err;

    generate
        for (genvar gi = 0; gi < SPLT_NUM; gi++) begin : g_hit
            assign w_hit[gi] = ((bus.i_icb_cmd_addr & SPLT_MASK[gi*AW +: AW]) ==
                                (SPLT_BASE[gi*AW +: AW] & SPLT_MASK[gi*AW +: AW]));
        end
    endgenerate

    // lowest matching port wins; a miss lands in the top select bit
    // (error slot when enabled, otherwise the last port acts as default)
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < SPLT_NUM; i++) begin
            if (!w_found && w_hit[i]) begin
                w_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        if (!w_found) begin
            w_sel[c_SEL_W-1] = 1'b1;
        end
    end

`ifdef SPLT_ERR_RSP_EN
    assign w_sel_err = w_sel[SPLT_NUM];
`else
    assign w_sel_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Tracking FIFO state
    // ------------------------------------------------------------------
    logic [c_SEL_W-1:0] r_fifo_sel_q [FIFO_DP];
    logic [c_SEL_W-1:0] w_fifo_sel_d [FIFO_DP];
`ifdef SPLT_ERR_RSP_EN
    // usr of error-slot commands, echoed back in the error response
    logic [USR_W-1:0]   r_fifo_usr_q [FIFO_DP];
    logic [USR_W-1:0]   w_fifo_usr_d [FIFO_DP];
`endif
    logic [c_PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [c_CNT_W-1:0] r_cnt_q,  w_cnt_d;

    logic               w_unfull;
    logic               w_unempty;
    logic               w_push;
    logic               w_pop;
    logic [c_SEL_W-1:0] w_head;
    logic               w_head_err;

    assign w_unfull  = (r_cnt_q != c_CNT_FULL);
    assign w_unempty = (r_cnt_q != '0);
    assign w_head    = r_fifo_sel_q[r_rptr_q];

`ifdef SPLT_ERR_RSP_EN
    assign w_head_err = w_head[SPLT_NUM];
`else
    assign w_head_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Command path: broadcast payload, qualify valid by decode and space
    // ------------------------------------------------------------------
    assign bus.o_bus_icb_cmd_vld   = {SPLT_NUM{bus.i_icb_cmd_vld & w_unfull}} &
                                     w_sel[SPLT_NUM-1:0];
    assign bus.i_icb_cmd_rdy       = w_unfull &
                                     ((|(w_sel[SPLT_NUM-1:0] & bus.o_bus_icb_cmd_rdy)) |
                                      w_sel_err);
    assign bus.o_bus_icb_cmd_read  = {SPLT_NUM{bus.i_icb_cmd_read}};
    assign bus.o_bus_icb_cmd_addr  = {SPLT_NUM{bus.i_icb_cmd_addr}};
    assign bus.o_bus_icb_cmd_wdata = {SPLT_NUM{bus.i_icb_cmd_wdata}};
    assign bus.o_bus_icb_cmd_wmask = {SPLT_NUM{bus.i_icb_cmd_wmask}};
    assign bus.o_bus_icb_cmd_usr   = {SPLT_NUM{bus.i_icb_cmd_usr}};

    assign w_push = bus.i_icb_cmd_vld & bus.i_icb_cmd_rdy;

    // ------------------------------------------------------------------
    // Response path: only the head slave is allowed to hand over
    // ------------------------------------------------------------------
    assign bus.o_bus_icb_rsp_rdy = {SPLT_NUM{bus.i_icb_rsp_rdy & w_unempty}} &
                                   w_head[SPLT_NUM-1:0];
    assign bus.i_icb_rsp_vld     = w_unempty &
                                   ((|(w_head[SPLT_NUM-1:0] & bus.o_bus_icb_rsp_vld)) |
                                    w_head_err);

    assign w_pop = bus.i_icb_rsp_vld & bus.i_icb_rsp_rdy;

    // one-hot OR mux of the head slave's response payload
    always_comb begin
        bus.i_icb_rsp_err   = 1'b0;
        bus.i_icb_rsp_rdata = '0;
        bus.i_icb_rsp_usr   = '0;
        for (int i = 0; i < SPLT_NUM; i++) begin
            if (w_head[i]) begin
                bus.i_icb_rsp_err   = bus.i_icb_rsp_err   | bus.o_bus_icb_rsp_err[i];
                bus.i_icb_rsp_rdata = bus.i_icb_rsp_rdata | bus.o_bus_icb_rsp_rdata[i*DW +: DW];
                bus.i_icb_rsp_usr   = bus.i_icb_rsp_usr   | bus.o_bus_icb_rsp_usr[i*USR_W +: USR_W];
            end
        end
`ifdef SPLT_ERR_RSP_EN
        if (w_head_err) begin
            bus.i_icb_rsp_err = 1'b1;
            bus.i_icb_rsp_usr = r_fifo_usr_q[r_rptr_q];
        end
`endif
    end

    // ------------------------------------------------------------------
    // FIFO next-state: write at wptr on push, advance rptr on pop,
    // occupancy unchanged when both happen together
    // ------------------------------------------------------------------
    always_comb begin
        w_fifo_sel_d = r_fifo_sel_q;
`ifdef SPLT_ERR_RSP_EN
        w_fifo_usr_d = r_fifo_usr_q;
`endif
        w_wptr_d     = r_wptr_q;
        w_rptr_d     = r_rptr_q;
        w_cnt_d      = r_cnt_q;
        if (w_push) begin
            w_fifo_sel_d[r_wptr_q] = w_sel;
`ifdef SPLT_ERR_RSP_EN
            w_fifo_usr_d[r_wptr_q] = bus.i_icb_cmd_usr;
`endif
            w_wptr_d = (r_wptr_q == c_PTR_LAST) ? '0 : r_wptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rptr_d = (r_rptr_q == c_PTR_LAST) ? '0 : r_rptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_d = r_cnt_q + 1'b1;
            2'b01:   w_cnt_d = r_cnt_q - 1'b1;
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    // FIFO registers; reset drops every outstanding entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DP; i++) begin
                r_fifo_sel_q[i] <= '0;
`ifdef SPLT_ERR_RSP_EN
                r_fifo_usr_q[i] <= '0;
`endif
            end
        end else begin
            r_wptr_q     <= w_wptr_d;
            r_rptr_q     <= w_rptr_d;
            r_cnt_q      <= w_cnt_d;
            r_fifo_sel_q <= w_fifo_sel_d;
`ifdef SPLT_ERR_RSP_EN
            r_fifo_usr_q <= w_fifo_usr_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_splt_me.sv
`default_nettype none
// ============================================================================
// Module      : tb_splt_me
// Description : Self-checking bench for splt_me: directed scenarios followed
//               by a randomized phase checked against a queue-based model.
//               Honours SPLT_ERR_RSP_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_splt_me;
    localparam int AW = 32, DW = 64, USR_W = 1, N = 4, DP = 2;
    localparam int ERRP = N;
    localparam logic [31:0] BASE_T [N] = '{32'h0000_0000, 32'h0200_0000,
                                           32'h1000_0000, 32'h8000_0000};
    localparam logic [31:0] MASK_T = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    splt_me_if #(.AW(AW), .DW(DW), .USR_W(USR_W), .SPLT_NUM(N)) bus_if ();

    splt_me #(.AW(AW), .DW(DW), .USR_W(USR_W), .SPLT_NUM(N), .FIFO_DP(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference decode: lowest matching region, miss -> error slot or last port
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK_T) == (BASE_T[i] & MASK_T)) return i;
`ifdef SPLT_ERR_RSP_EN
        return ERRP;
`else
        return N - 1;
`endif
    endfunction

    task automatic idle();
        bus_if.i_icb_cmd_vld       = 1'b0;
        bus_if.i_icb_cmd_read      = 1'b0;
        bus_if.i_icb_cmd_addr      = '0;
        bus_if.i_icb_cmd_wdata     = '0;
        bus_if.i_icb_cmd_wmask     = '0;
        bus_if.i_icb_cmd_usr       = '0;
        bus_if.i_icb_rsp_rdy       = 1'b0;
        bus_if.o_bus_icb_cmd_rdy   = '0;
        bus_if.o_bus_icb_rsp_vld   = '0;
        bus_if.o_bus_icb_rsp_err   = '0;
        bus_if.o_bus_icb_rsp_rdata = '0;
        bus_if.o_bus_icb_rsp_usr   = '0;
    endtask

    task automatic cmd(input logic [31:0] a, input logic rd, input logic u);
        bus_if.i_icb_cmd_vld   = 1'b1;
        bus_if.i_icb_cmd_addr  = a;
        bus_if.i_icb_cmd_read  = rd;
        bus_if.i_icb_cmd_usr   = u;
        bus_if.i_icb_cmd_wdata = {a, ~a};
        bus_if.i_icb_cmd_wmask = 8'hA5;
    endtask

    task automatic srsp(input int p, input logic [63:0] d, input logic e, input logic u);
        bus_if.o_bus_icb_rsp_rdata[p*DW +: DW] = d;
        bus_if.o_bus_icb_rsp_err[p]            = e;
        bus_if.o_bus_icb_rsp_usr[p]            = u;
    endtask

    // inputs change at the falling edge; outputs are checked 1 unit later
    task automatic adv();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    int          q_port [$];
    logic        q_usr  [$];

    initial begin
        int t, h, k;
        logic full, e_crdy, e_rvld;
        logic [3:0] e_bvld, e_brdy;
        logic [63:0] e_rdata;
        logic e_err, e_usr;

        idle();
        adv(); adv();
        // ---------------- reset state ----------------
        bus_if.o_bus_icb_rsp_vld = 4'hF;
        bus_if.i_icb_rsp_rdy     = 1'b1;
        #1;
        chk("rst_rsp_vld", bus_if.i_icb_rsp_vld, 1'b0);
        chk("rst_bus_rsp_rdy", bus_if.o_bus_icb_rsp_rdy, 4'h0);
        adv();
        rst = 1'b0;
        idle();
        // ---------------- single read to slave 3 ----------------
        bus_if.o_bus_icb_cmd_rdy = 4'hF;
        cmd(32'h8000_0010, 1'b1, 1'b0);
        #1;
        chk("t1_cmd_rdy", bus_if.i_icb_cmd_rdy, 1'b1);
        chk("t1_bus_cmd_vld", bus_if.o_bus_icb_cmd_vld, 4'b1000);
        chk("t1_bus_addr3", bus_if.o_bus_icb_cmd_addr[3*AW +: AW], 32'h8000_0010);
        chk("t1_bus_read3", bus_if.o_bus_icb_cmd_read[3], 1'b1);
        adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        #1;
        chk("t1_no_rsp_yet", bus_if.i_icb_rsp_vld, 1'b0);
        adv();
        bus_if.o_bus_icb_rsp_vld = 4'b1000;
        srsp(3, 64'hDEAD_BEEF, 1'b0, 1'b0);
        bus_if.i_icb_rsp_rdy = 1'b1;
        #1;
        chk("t1_rsp_vld", bus_if.i_icb_rsp_vld, 1'b1);
        chk("t1_rsp_rdata", bus_if.i_icb_rsp_rdata, 64'hDEAD_BEEF);
        chk("t1_rsp_err", bus_if.i_icb_rsp_err, 1'b0);
        chk("t1_bus_rsp_rdy", bus_if.o_bus_icb_rsp_rdy, 4'b1000);
        adv();
        idle();
        // ---------------- ordering: slave2 then slave0 ----------------
        bus_if.o_bus_icb_cmd_rdy = 4'hF;
        cmd(32'h1000_0000, 1'b0, 1'b0);
        #1;
        chk("t2_vld_p2", bus_if.o_bus_icb_cmd_vld, 4'b0100);
        adv();
        cmd(32'h0000_0004, 1'b1, 1'b0);
        #1;
        chk("t2_vld_p0", bus_if.o_bus_icb_cmd_vld, 4'b0001);
        adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        bus_if.i_icb_rsp_rdy = 1'b1;
        bus_if.o_bus_icb_rsp_vld = 4'b0001;
        srsp(0, 64'hAAAA, 1'b0, 1'b0);
        #1;
        chk("t2_early_p0_blocked", bus_if.i_icb_rsp_vld, 1'b0);
        chk("t2_rdy_head_only", bus_if.o_bus_icb_rsp_rdy, 4'b0100);
        adv();
        bus_if.o_bus_icb_rsp_vld = 4'b0101;
        srsp(2, 64'hBBBB, 1'b0, 1'b0);
        #1;
        chk("t2_first_p2", bus_if.i_icb_rsp_rdata, 64'hBBBB);
        chk("t2_first_vld", bus_if.i_icb_rsp_vld, 1'b1);
        adv();
        bus_if.o_bus_icb_rsp_vld = 4'b0001;
        #1;
        chk("t2_second_p0", bus_if.i_icb_rsp_rdata, 64'hAAAA);
        chk("t2_second_rdy", bus_if.o_bus_icb_rsp_rdy, 4'b0001);
        adv();
        idle();
        // ---------------- full FIFO, then push with pop ----------------
        bus_if.o_bus_icb_cmd_rdy = 4'hF;
        cmd(32'h8000_0000, 1'b1, 1'b0); adv();
        cmd(32'h1000_0008, 1'b1, 1'b0); adv();
        cmd(32'h0000_0100, 1'b1, 1'b0);
        bus_if.i_icb_rsp_rdy = 1'b1;
        bus_if.o_bus_icb_rsp_vld = 4'b1000;
        srsp(3, 64'h1111, 1'b0, 1'b0);
        #1;
        chk("t3_full_cmd_rdy", bus_if.i_icb_cmd_rdy, 1'b0);
        chk("t3_full_bus_vld", bus_if.o_bus_icb_cmd_vld, 4'h0);
        chk("t3_pop_at_full", bus_if.i_icb_rsp_rdata, 64'h1111);
        adv();
        bus_if.o_bus_icb_rsp_vld = 4'b0100;
        srsp(2, 64'h2222, 1'b0, 1'b0);
        #1;
        chk("t3_third_accept", bus_if.i_icb_cmd_rdy, 1'b1);
        chk("t3_third_vld", bus_if.o_bus_icb_cmd_vld, 4'b0001);
        chk("t3_pushpop_rdata", bus_if.i_icb_rsp_rdata, 64'h2222);
        adv();
        bus_if.o_bus_icb_rsp_vld = 4'b0000;
        cmd(32'h8000_0040, 1'b1, 1'b0);
        #1;
        chk("t3_one_free", bus_if.i_icb_cmd_rdy, 1'b1);
        adv();
        cmd(32'h0000_0000, 1'b1, 1'b0);
        #1;
        chk("t3_full_again", bus_if.i_icb_cmd_rdy, 1'b0);
        adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        bus_if.o_bus_icb_rsp_vld = 4'b1001;
        srsp(0, 64'h3333, 1'b0, 1'b0);
        srsp(3, 64'h4444, 1'b0, 1'b0);
        #1;
        chk("t3_order_a", bus_if.i_icb_rsp_rdata, 64'h3333);
        chk("t3_order_a_rdy", bus_if.o_bus_icb_rsp_rdy, 4'b0001);
        adv();
        #1;
        chk("t3_order_b", bus_if.i_icb_rsp_rdata, 64'h4444);
        chk("t3_order_b_rdy", bus_if.o_bus_icb_rsp_rdy, 4'b1000);
        adv();
        bus_if.o_bus_icb_rsp_vld = 4'hF;
        #1;
        chk("t3_empty", bus_if.i_icb_rsp_vld, 1'b0);
        adv();
        idle();
        // ---------------- unmatched address ----------------
        cmd(32'h5000_0000, 1'b1, 1'b1);
`ifdef SPLT_ERR_RSP_EN
        #1;
        chk("t4_err_no_bus_vld", bus_if.o_bus_icb_cmd_vld, 4'h0);
        chk("t4_err_cmd_rdy", bus_if.i_icb_cmd_rdy, 1'b1);
        adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        bus_if.i_icb_rsp_rdy = 1'b1;
        #1;
        chk("t4_err_rsp_vld", bus_if.i_icb_rsp_vld, 1'b1);
        chk("t4_err_flag", bus_if.i_icb_rsp_err, 1'b1);
        chk("t4_err_rdata", bus_if.i_icb_rsp_rdata, 64'h0);
        chk("t4_err_usr", bus_if.i_icb_rsp_usr, 1'b1);
        adv();
`else
        #1;
        chk("t4_dflt_bus_vld", bus_if.o_bus_icb_cmd_vld, 4'b1000);
        chk("t4_dflt_wait_rdy", bus_if.i_icb_cmd_rdy, 1'b0);
        bus_if.o_bus_icb_cmd_rdy = 4'b1000;
        #1;
        chk("t4_dflt_cmd_rdy", bus_if.i_icb_cmd_rdy, 1'b1);
        adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        bus_if.i_icb_rsp_rdy = 1'b1;
        bus_if.o_bus_icb_rsp_vld = 4'b1000;
        srsp(3, 64'h5555, 1'b0, 1'b1);
        #1;
        chk("t4_dflt_rsp", bus_if.i_icb_rsp_rdata, 64'h5555);
        chk("t4_dflt_usr", bus_if.i_icb_rsp_usr, 1'b1);
        adv();
`endif
        idle();
        // ---------------- reset with two outstanding ----------------
        bus_if.o_bus_icb_cmd_rdy = 4'hF;
        cmd(32'h8000_0000, 1'b1, 1'b0); adv();
        cmd(32'h1000_0000, 1'b1, 1'b0); adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        rst = 1'b1;
        adv();
        rst = 1'b0;
        bus_if.o_bus_icb_rsp_vld = 4'hF;
        bus_if.i_icb_rsp_rdy = 1'b1;
        cmd(32'h0000_0010, 1'b1, 1'b0);
        #1;
        chk("t5_rsp_vld_cleared", bus_if.i_icb_rsp_vld, 1'b0);
        chk("t5_bus_rdy_cleared", bus_if.o_bus_icb_rsp_rdy, 4'h0);
        chk("t5_new_cmd_rdy", bus_if.i_icb_cmd_rdy, 1'b1);
        adv();
        bus_if.i_icb_cmd_vld = 1'b0;
        srsp(0, 64'h6666, 1'b0, 1'b0);
        #1;
        chk("t5_new_rsp", bus_if.i_icb_rsp_rdata, 64'h6666);
        chk("t5_new_rsp_rdy", bus_if.o_bus_icb_rsp_rdy, 4'b0001);
        adv();
        idle();
        #1;
        chk("t5_drained", bus_if.i_icb_rsp_vld, 1'b0);
        adv();
        // ---------------- randomized traffic vs. queue model ----------------
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'h1000_0000;
                2: a = 32'h0000_0000;
                3: a = 32'h0200_0000;
                4: a = 32'h5000_0000;
                default: a = 32'hF000_0000;
            endcase
            a = a | ($urandom() & 32'h0FFF_FFFF);
            bus_if.i_icb_cmd_vld   = ($urandom_range(0, 3) != 0);
            bus_if.i_icb_cmd_addr  = a;
            bus_if.i_icb_cmd_read  = $urandom_range(0, 1);
            bus_if.i_icb_cmd_usr   = $urandom_range(0, 1);
            bus_if.i_icb_cmd_wdata = {$urandom(), $urandom()};
            bus_if.i_icb_cmd_wmask = $urandom_range(0, 255);
            bus_if.i_icb_rsp_rdy   = ($urandom_range(0, 3) != 0);
            bus_if.o_bus_icb_cmd_rdy = $urandom_range(0, 15);
            bus_if.o_bus_icb_rsp_vld = $urandom_range(0, 15);
            for (int p = 0; p < N; p++)
                srsp(p, {$urandom(), $urandom()}, $urandom_range(0, 1), $urandom_range(0, 1));
            #1;
            t      = decode(a);
            full   = (q_port.size() == DP);
            e_crdy = !full && ((t == ERRP) ? 1'b1 : bus_if.o_bus_icb_cmd_rdy[t]);
            e_bvld = (bus_if.i_icb_cmd_vld && !full && t != ERRP) ? (4'b0001 << t) : 4'b0000;
            e_rvld = 1'b0;
            e_brdy = 4'b0000;
            if (q_port.size() > 0) begin
                h = q_port[0];
                e_rvld = (h == ERRP) ? 1'b1 : bus_if.o_bus_icb_rsp_vld[h];
                if (bus_if.i_icb_rsp_rdy && h != ERRP) e_brdy = 4'b0001 << h;
            end
            chk("rnd_cmd_rdy", bus_if.i_icb_cmd_rdy, e_crdy);
            chk("rnd_bus_cmd_vld", bus_if.o_bus_icb_cmd_vld, e_bvld);
            chk("rnd_rsp_vld", bus_if.i_icb_rsp_vld, e_rvld);
            chk("rnd_bus_rsp_rdy", bus_if.o_bus_icb_rsp_rdy, e_brdy);
            k = $urandom_range(0, N - 1);
            chk("rnd_bc_addr", bus_if.o_bus_icb_cmd_addr[k*AW +: AW], a);
            chk("rnd_bc_wdata", bus_if.o_bus_icb_cmd_wdata[k*DW +: DW], bus_if.i_icb_cmd_wdata);
            chk("rnd_bc_misc", {bus_if.o_bus_icb_cmd_wmask[k*8 +: 8], bus_if.o_bus_icb_cmd_read[k],
                                bus_if.o_bus_icb_cmd_usr[k]},
                {bus_if.i_icb_cmd_wmask, bus_if.i_icb_cmd_read, bus_if.i_icb_cmd_usr});
            if (e_rvld) begin
                if (h == ERRP) begin
                    e_rdata = 64'h0; e_err = 1'b1; e_usr = q_usr[0];
                end else begin
                    e_rdata = bus_if.o_bus_icb_rsp_rdata[h*DW +: DW];
                    e_err   = bus_if.o_bus_icb_rsp_err[h];
                    e_usr   = bus_if.o_bus_icb_rsp_usr[h];
                end
                chk("rnd_rsp_rdata", bus_if.i_icb_rsp_rdata, e_rdata);
                chk("rnd_rsp_err_usr", {bus_if.i_icb_rsp_err, bus_if.i_icb_rsp_usr}, {e_err, e_usr});
                if (bus_if.i_icb_rsp_rdy) begin
                    void'(q_port.pop_front());
                    void'(q_usr.pop_front());
                end
            end
            if (bus_if.i_icb_cmd_vld && e_crdy) begin
                q_port.push_back(t);
                q_usr.push_back(bus_if.i_icb_cmd_usr);
            end
            adv();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
